// File: rtl/mmu_utlb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmu_utlb                                                      |
// | Purpose  : Fully-associative, ASID-tagged micro-TLB in front of the      |
// |            shared main TLB. Resolves kseg0/kseg1 locally, caches 4 KB    |
// |            mapped translations and refills them through a req/resp       |
// |            handshake with the main TLB. Counts mapped hits and misses.   |
// | Ports    : clk/rst            - clock, synchronous active-high reset     |
// |            i_asid, i_kseg0_uncached, i_is_user_mode - CPU context         |
// |            i_flush            - invalidate all entries                   |
// |            i_req_* / o_req_ready - lookup request handshake              |
// |            o_resp_*           - registered one-cycle lookup result       |
// |            o_tlb_req_*        - refill request to main TLB               |
// |            i_tlb_resp_*       - main TLB answer                          |
// |            o_stat_hits/misses - mapped lookup statistics                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mmu_utlb #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_asid,
  input  logic        i_kseg0_uncached,
  input  logic        i_is_user_mode,
  input  logic        i_flush,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_vaddr,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_paddr,
  output logic        o_resp_miss,
  output logic        o_resp_invalid,
  output logic        o_resp_illegal,
  output logic        o_resp_dirty,
  output logic        o_resp_uncached,
  output logic        o_tlb_req_valid,
  output logic [31:0] o_tlb_req_vaddr,
  input  logic        i_tlb_resp_valid,
  input  logic [19:0] i_tlb_resp_pfn,
  input  logic        i_tlb_resp_miss,
  input  logic        i_tlb_resp_v,
  input  logic        i_tlb_resp_dirty,
  input  logic        i_tlb_resp_global,
  output logic [31:0] o_stat_hits,
  output logic [31:0] o_stat_misses
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_TLB = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  // Entry storage; only the valid bits need a reset value.
  logic [ENTRIES-1:0] r_valid;
  logic [19:0]        r_vpn   [ENTRIES];
  logic [7:0]         r_asid  [ENTRIES];
  logic               r_glob  [ENTRIES];
  logic [19:0]        r_pfn   [ENTRIES];
  logic               r_dirty [ENTRIES];
  logic [IDX_W-1:0]   r_ptr;

  logic        r_resp_valid, r_resp_miss, r_resp_invalid, r_resp_illegal;
  logic        r_resp_dirty, r_resp_uncached;
  logic [31:0] r_resp_paddr;
  logic        r_tlb_req_valid;
  logic [31:0] r_tlb_req_vaddr;
  logic [7:0]  r_req_asid;
  logic        r_fill_ok;   // cleared by any flush while the refill is pending
  logic [31:0] r_hits, r_misses;

  logic               w_accept, w_illegal, w_unmapped, w_hit, w_miss;
  logic               w_fill, w_has_free;
  logic [ENTRIES-1:0] w_hit_vec;
  logic [19:0]        w_hit_pfn;
  logic               w_hit_dirty;
  logic [IDX_W-1:0]   w_free_idx, w_victim;

  assign w_accept   = i_req_valid && (r_state == ST_IDLE);
  assign w_illegal  = i_is_user_mode && i_req_vaddr[31];
  assign w_unmapped = (i_req_vaddr[31:30] == 2'b10);
  // A flush in the accept cycle forces a miss so stale entries are never used.
  assign w_hit      = (|w_hit_vec) && !i_flush;
  assign w_miss     = w_accept && !w_illegal && !w_unmapped && !w_hit;
  assign w_has_free = ~&r_valid;
  assign w_victim   = w_has_free ? w_free_idx : r_ptr;
  assign w_fill     = (r_state == ST_WAIT_TLB) && i_tlb_resp_valid &&
                      !i_tlb_resp_miss && i_tlb_resp_v && r_fill_ok && !i_flush;

  // Match and free-slot search; descending loop makes the lowest index win.
  always_comb begin
    w_hit_vec   = '0;
    w_hit_pfn   = '0;
    w_hit_dirty = 1'b0;
    w_free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      w_hit_vec[i] = r_valid[i] && (r_vpn[i] == i_req_vaddr[31:12]) &&
                     (r_glob[i] || (r_asid[i] == i_asid));
      if (w_hit_vec[i]) begin
        w_hit_pfn   = r_pfn[i];
        w_hit_dirty = r_dirty[i];
      end
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_miss) w_state_nxt = ST_WAIT_TLB;
      ST_WAIT_TLB: if (i_tlb_resp_valid) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid         <= '0;
      r_ptr           <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_paddr    <= '0;
      r_resp_miss     <= 1'b0;
      r_resp_invalid  <= 1'b0;
      r_resp_illegal  <= 1'b0;
      r_resp_dirty    <= 1'b0;
      r_resp_uncached <= 1'b0;
      r_tlb_req_valid <= 1'b0;
      r_tlb_req_vaddr <= '0;
      r_req_asid      <= '0;
      r_fill_ok       <= 1'b0;
      r_hits          <= '0;
      r_misses        <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_resp_miss     <= 1'b0;
        r_resp_invalid  <= 1'b0;
        r_resp_illegal  <= 1'b0;
        r_resp_dirty    <= 1'b0;
        r_resp_uncached <= 1'b0;
        r_resp_paddr    <= '0;
        if (w_illegal) begin
          r_resp_valid   <= 1'b1;
          r_resp_illegal <= 1'b1;
        end else if (w_unmapped) begin
          r_resp_valid    <= 1'b1;
          r_resp_paddr    <= {3'b000, i_req_vaddr[28:0]};
          r_resp_dirty    <= 1'b1;
          r_resp_uncached <= (i_req_vaddr[31:29] == 3'b101) ||
                             (i_kseg0_uncached && (i_req_vaddr[31:29] == 3'b100));
        end else if (w_hit) begin
          r_resp_valid <= 1'b1;
          r_resp_paddr <= {w_hit_pfn, i_req_vaddr[11:0]};
          r_resp_dirty <= w_hit_dirty;
          r_hits       <= r_hits + 32'd1;
        end else begin
          r_misses        <= r_misses + 32'd1;
          r_tlb_req_valid <= 1'b1;
          r_tlb_req_vaddr <= i_req_vaddr;
          r_req_asid      <= i_asid;
          r_fill_ok       <= 1'b1;
        end
      end
      if (r_state == ST_WAIT_TLB) begin
        if (i_flush) r_fill_ok <= 1'b0;
        if (i_tlb_resp_valid) begin
          r_tlb_req_valid <= 1'b0;
          r_resp_valid    <= 1'b1;
          r_resp_paddr    <= {i_tlb_resp_pfn, r_tlb_req_vaddr[11:0]};
          r_resp_miss     <= i_tlb_resp_miss;
          r_resp_invalid  <= !i_tlb_resp_miss && !i_tlb_resp_v;
          r_resp_illegal  <= 1'b0;
          r_resp_dirty    <= i_tlb_resp_dirty;
          r_resp_uncached <= 1'b0;
        end
      end
      if (w_fill) begin
        r_valid[w_victim] <= 1'b1;
        if (!w_has_free) r_ptr <= r_ptr + IDX_W'(1);
      end
      if (i_flush) r_valid <= '0;
    end
  end

  // Payload of the entries; written only alongside its valid bit.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_vpn[w_victim]   <= r_tlb_req_vaddr[31:12];
      r_asid[w_victim]  <= r_req_asid;
      r_glob[w_victim]  <= i_tlb_resp_global;
      r_pfn[w_victim]   <= i_tlb_resp_pfn;
      r_dirty[w_victim] <= i_tlb_resp_dirty;
    end
  end

  assign o_req_ready     = (r_state == ST_IDLE);
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_paddr    = r_resp_paddr;
  assign o_resp_miss     = r_resp_miss;
  assign o_resp_invalid  = r_resp_invalid;
  assign o_resp_illegal  = r_resp_illegal;
  assign o_resp_dirty    = r_resp_dirty;
  assign o_resp_uncached = r_resp_uncached;
  assign o_tlb_req_valid = r_tlb_req_valid;
  assign o_tlb_req_vaddr = r_tlb_req_vaddr;
  assign o_stat_hits     = r_hits;
  assign o_stat_misses   = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_mmu_utlb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mmu_utlb                                                   |
// | Purpose  : Directed self-checking bench for mmu_utlb (ENTRIES = 4).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mmu_utlb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_asid = 8'd0;
  logic        i_kseg0_uncached = 1'b0;
  logic        i_is_user_mode = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_vaddr = '0;
  logic        o_req_ready, o_resp_valid, o_resp_miss, o_resp_invalid;
  logic        o_resp_illegal, o_resp_dirty, o_resp_uncached, o_tlb_req_valid;
  logic [31:0] o_resp_paddr, o_tlb_req_vaddr, o_stat_hits, o_stat_misses;
  logic        i_tlb_resp_valid = 1'b0;
  logic [19:0] i_tlb_resp_pfn = '0;
  logic        i_tlb_resp_miss = 1'b0;
  logic        i_tlb_resp_v = 1'b0;
  logic        i_tlb_resp_dirty = 1'b0;
  logic        i_tlb_resp_global = 1'b0;

  int total = 0;
  int bad   = 0;

  mmu_utlb #(.ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .i_asid(i_asid), .i_kseg0_uncached(i_kseg0_uncached),
    .i_is_user_mode(i_is_user_mode), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .i_req_vaddr(i_req_vaddr), .o_req_ready(o_req_ready),
    .o_resp_valid(o_resp_valid), .o_resp_paddr(o_resp_paddr), .o_resp_miss(o_resp_miss),
    .o_resp_invalid(o_resp_invalid), .o_resp_illegal(o_resp_illegal),
    .o_resp_dirty(o_resp_dirty), .o_resp_uncached(o_resp_uncached),
    .o_tlb_req_valid(o_tlb_req_valid), .o_tlb_req_vaddr(o_tlb_req_vaddr),
    .i_tlb_resp_valid(i_tlb_resp_valid), .i_tlb_resp_pfn(i_tlb_resp_pfn),
    .i_tlb_resp_miss(i_tlb_resp_miss), .i_tlb_resp_v(i_tlb_resp_v),
    .i_tlb_resp_dirty(i_tlb_resp_dirty), .i_tlb_resp_global(i_tlb_resp_global),
    .o_stat_hits(o_stat_hits), .o_stat_misses(o_stat_misses)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one lookup for exactly one accepting edge.
  task automatic req(input logic [31:0] va);
    i_req_valid = 1'b1;
    i_req_vaddr = va;
    step();
    i_req_valid = 1'b0;
  endtask

  task automatic answer(input logic [19:0] pfn, input logic miss, input logic v,
                        input logic d, input logic g);
    i_tlb_resp_valid  = 1'b1;
    i_tlb_resp_pfn    = pfn;
    i_tlb_resp_miss   = miss;
    i_tlb_resp_v      = v;
    i_tlb_resp_dirty  = d;
    i_tlb_resp_global = g;
    step();
    i_tlb_resp_valid  = 1'b0;
  endtask

  // Miss followed by a clean refill with V=1.
  task automatic miss_fill(input string tag, input logic [31:0] va, input logic [19:0] pfn,
                           input logic d, input logic g, input logic [31:0] exp_misses);
    req(va);
    check({tag, "_tlbreq"}, 32'(o_tlb_req_valid), 32'd1);
    check({tag, "_tlbva"}, o_tlb_req_vaddr, va);
    check({tag, "_misses"}, o_stat_misses, exp_misses);
    answer(pfn, 1'b0, 1'b1, d, g);
    check({tag, "_rv"}, 32'(o_resp_valid), 32'd1);
    check({tag, "_pa"}, o_resp_paddr, {pfn, va[11:0]});
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] va, input logic [31:0] pa,
                            input logic d, input logic [31:0] exp_hits);
    req(va);
    check({tag, "_rv"}, 32'(o_resp_valid), 32'd1);
    check({tag, "_pa"}, o_resp_paddr, pa);
    check({tag, "_d"}, 32'(o_resp_dirty), 32'(d));
    check({tag, "_hits"}, o_stat_hits, exp_hits);
  endtask

  initial begin
    // Reset
    repeat (3) step();
    rst = 1'b0;
    check("rst_rv", 32'(o_resp_valid), 32'd0);
    check("rst_tlbreq", 32'(o_tlb_req_valid), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd1);
    check("rst_hits", o_stat_hits, 32'd0);
    check("rst_misses", o_stat_misses, 32'd0);

    // Unmapped segments
    req(32'hBFC0_0000);
    check("k1_rv", 32'(o_resp_valid), 32'd1);
    check("k1_pa", o_resp_paddr, 32'h1FC0_0000);
    check("k1_unc", 32'(o_resp_uncached), 32'd1);
    check("k1_d", 32'(o_resp_dirty), 32'd1);
    check("k1_tlbreq", 32'(o_tlb_req_valid), 32'd0);
    check("k1_misses", o_stat_misses, 32'd0);
    check("k1_hits", o_stat_hits, 32'd0);
    req(32'h8000_1000);
    check("k0c_pa", o_resp_paddr, 32'h0000_1000);
    check("k0c_unc", 32'(o_resp_uncached), 32'd0);
    i_kseg0_uncached = 1'b1;
    req(32'h8000_1000);
    check("k0u_unc", 32'(o_resp_uncached), 32'd1);
    i_kseg0_uncached = 1'b0;

    // First mapped miss with a held request, then refill
    i_asid = 8'd5;
    req(32'h0040_0123);
    check("m1_rv", 32'(o_resp_valid), 32'd0);
    check("m1_ready", 32'(o_req_ready), 32'd0);
    check("m1_tlbva", o_tlb_req_vaddr, 32'h0040_0123);
    step();
    check("m1_hold", 32'(o_tlb_req_valid), 32'd1);
    answer(20'h12345, 1'b0, 1'b1, 1'b0, 1'b0);
    check("m1_rv2", 32'(o_resp_valid), 32'd1);
    check("m1_pa", o_resp_paddr, 32'h1234_5123);
    check("m1_d", 32'(o_resp_dirty), 32'd0);
    check("m1_miss", 32'(o_resp_miss), 32'd0);
    check("m1_tlbreq_low", 32'(o_tlb_req_valid), 32'd0);
    check("m1_misses", o_stat_misses, 32'd1);
    check("m1_ready2", 32'(o_req_ready), 32'd1);
    expect_hit("h1", 32'h0040_0123, 32'h1234_5123, 1'b0, 32'd1);

    // Back-to-back hits with req_valid held high
    i_req_valid = 1'b1;
    i_req_vaddr = 32'h0040_0010;
    step();
    check("b2b_a", o_resp_paddr, 32'h1234_5010);
    i_req_vaddr = 32'h0040_0FFF;
    step();
    i_req_valid = 1'b0;
    check("b2b_rv", 32'(o_resp_valid), 32'd1);
    check("b2b_b", o_resp_paddr, 32'h1234_5FFF);
    check("b2b_hits", o_stat_hits, 32'd3);

    // ASID filtering and global pages
    i_asid = 8'd6;
    miss_fill("asid6", 32'h0040_0123, 20'h0ABCD, 1'b1, 1'b1, 32'd2);
    check("asid6_d", 32'(o_resp_dirty), 32'd1);
    i_asid = 8'd9;
    expect_hit("glob", 32'h0040_0123, 32'h0ABC_D123, 1'b1, 32'd4);

    // Flush, then fill 5 pages into 4 entries
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    miss_fill("p1", 32'h1000_0000, 20'h00010, 1'b0, 1'b0, 32'd3);
    miss_fill("p2", 32'h2000_0000, 20'h00020, 1'b0, 1'b0, 32'd4);
    miss_fill("p3", 32'h3000_0000, 20'h00030, 1'b0, 1'b0, 32'd5);
    miss_fill("p4", 32'h4000_0000, 20'h00040, 1'b0, 1'b0, 32'd6);
    miss_fill("p5", 32'h5000_0000, 20'h00050, 1'b1, 1'b0, 32'd7);
    expect_hit("p2hit", 32'h2000_0ABC, 32'h0002_0ABC, 1'b0, 32'd5);
    expect_hit("p5hit", 32'h5000_0ABC, 32'h0005_0ABC, 1'b1, 32'd6);

    // Page 1 was the victim; main TLB miss then invalid, neither fills
    req(32'h1000_0000);
    check("p1re_tlbreq", 32'(o_tlb_req_valid), 32'd1);
    check("p1re_misses", o_stat_misses, 32'd8);
    answer(20'h00000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tmiss_rv", 32'(o_resp_valid), 32'd1);
    check("tmiss_miss", 32'(o_resp_miss), 32'd1);
    check("tmiss_inv", 32'(o_resp_invalid), 32'd0);
    req(32'h1000_0000);
    check("inv_tlbreq", 32'(o_tlb_req_valid), 32'd1);
    answer(20'h00011, 1'b0, 1'b0, 1'b0, 1'b0);
    check("inv_miss", 32'(o_resp_miss), 32'd0);
    check("inv_inv", 32'(o_resp_invalid), 32'd1);

    // Flush while waiting: response still delivered, fill dropped
    req(32'h1000_0000);
    check("fw_misses", o_stat_misses, 32'd10);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    answer(20'h77777, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fw_rv", 32'(o_resp_valid), 32'd1);
    check("fw_pa", o_resp_paddr, 32'h7777_7000);
    check("fw_inv", 32'(o_resp_invalid), 32'd0);
    miss_fill("fw_p2", 32'h2000_0000, 20'h00022, 1'b0, 1'b0, 32'd11);
    miss_fill("fw_p1", 32'h1000_0000, 20'h00011, 1'b0, 1'b0, 32'd12);

    // Flush in the accept cycle turns a would-be hit into a miss
    i_flush = 1'b1;
    req(32'h1000_0000);
    i_flush = 1'b0;
    check("fa_rv", 32'(o_resp_valid), 32'd0);
    check("fa_tlbreq", 32'(o_tlb_req_valid), 32'd1);
    check("fa_misses", o_stat_misses, 32'd13);
    answer(20'h00000, 1'b1, 1'b0, 1'b0, 1'b0);

    // User-mode address error
    i_is_user_mode = 1'b1;
    req(32'h8000_0000);
    check("ill_rv", 32'(o_resp_valid), 32'd1);
    check("ill_ill", 32'(o_resp_illegal), 32'd1);
    check("ill_d", 32'(o_resp_dirty), 32'd0);
    check("ill_unc", 32'(o_resp_uncached), 32'd0);
    check("ill_tlbreq", 32'(o_tlb_req_valid), 32'd0);
    check("ill_misses", o_stat_misses, 32'd13);
    check("ill_hits", o_stat_hits, 32'd6);
    i_is_user_mode = 1'b0;

    // Reset in the middle of a refill; the late answer is ignored
    req(32'h3000_0000);
    check("rm_tlbreq", 32'(o_tlb_req_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_tlbreq_low", 32'(o_tlb_req_valid), 32'd0);
    check("rm_ready", 32'(o_req_ready), 32'd1);
    check("rm_misses", o_stat_misses, 32'd0);
    answer(20'h33333, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rm_late_rv", 32'(o_resp_valid), 32'd0);
    req(32'h2000_0000);
    check("rm_cleared", 32'(o_tlb_req_valid), 32'd1);
    check("rm_misses2", o_stat_misses, 32'd1);
    answer(20'h00020, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
